aq32_ebus_slave: RTL

//  Parametrised external Z80 bus slave front end for the Aquarius32 core. It synchronises
//  RD#/WR#/MREQ#/IORQ# into clk, detects falling-edge bus strobes, and queues each cycle
//  (addr, data, rd/wr, mem/io) into a FIFO drained by the core over valid/ready. Read

---
 rtl/aq32_ebus_slave_if.sv | 44 ++++
 rtl/aq32_ebus_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aq32_ebus_slave_if.sv
// Bus-side bundle for the Aquarius32 external Z80 bus slave.
// Carries the raw Z80 bus pins, the core-facing transaction FIFO head and
// read-response strobe, the bus data driver, and the sticky error flags.
//   slave  : the aq32_ebus_slave front end
//   master : the Z80 bus and the core together (drive strobes, pop, respond)
interface aq32_ebus_slave_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] ebus_a;
  logic [DATA_W-1:0] ebus_d_in;
  logic              ebus_rd_n;
  logic              ebus_wr_n;
  logic              ebus_mreq_n;
  logic              ebus_iorq_n;
  logic              txn_valid;
  logic              txn_ready;
  logic [ADDR_W-1:0] txn_addr;
  logic [DATA_W-1:0] txn_wrdata;
  logic              txn_is_wr;
  logic              txn_is_io;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [DATA_W-1:0] ebus_d_out;
  logic              ebus_d_oe;
  logic              overflow;
  logic              late_rsp;
  logic              proto_err;
  logic              err_clr;

  modport slave (
    input  ebus_a, ebus_d_in, ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n,
    input  txn_ready, rsp_valid, rsp_data, err_clr,
    output txn_valid, txn_addr, txn_wrdata, txn_is_wr, txn_is_io,
    output ebus_d_out, ebus_d_oe, overflow, late_rsp, proto_err
  );

  modport master (
    output ebus_a, ebus_d_in, ebus_rd_n, ebus_wr_n, ebus_mreq_n, ebus_iorq_n,
    output txn_ready, rsp_valid, rsp_data, err_clr,
    input  txn_valid, txn_addr, txn_wrdata, txn_is_wr, txn_is_io,
    input  ebus_d_out, ebus_d_oe, overflow, late_rsp, proto_err
  );
endinterface

// File: rtl/aq32_ebus_slave.sv
// External Z80 bus slave front end for the Aquarius32 core.
// Synchronises RD#/WR#/MREQ#/IORQ# into clk, turns falling strobe edges into
// transactions queued in a small FIFO for the core, and drives read data
// back onto the bus from the core's response until RD# is released.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      aq32_ebus_slave_if.slave: raw bus pins, FIFO head (valid/ready),
//            read response, bus data driver, sticky error flags + clear
module aq32_ebus_slave #(
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  aq32_ebus_slave_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned QL_W  = SYNC_STAGES - 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              is_wr;
    logic              is_io;
  } txn_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] rd_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic [QL_W-1:0]        mreq_sync;
  logic [QL_W-1:0]        iorq_sync;

  logic [DATA_W-1:0] wdata_q;

  txn_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  state_t            state;
  state_t            state_nxt;
  logic              d_ld;
  logic              late_set;
  logic              fsm_perr;
  logic              d_oe_q;
  logic [DATA_W-1:0] d_out_q;

  logic overflow_q;
  logic late_rsp_q;
  logic proto_err_q;

  logic rd_stb;
  logic wr_stb;
  logic rd_hi;
  logic mreq_q;
  logic iorq_q;
  logic cyc_ok;
  logic push_wr;
  logic push_rd;
  logic push;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;
  logic both_stb;
  txn_t new_txn;
  txn_t head;

  // Strobe synchronisers; idle bus level is 1. Qualifiers only need to reach
  // the stage that lines up with the strobe's newer tap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_sync   <= '1;
      wr_sync   <= '1;
      mreq_sync <= '1;
      iorq_sync <= '1;
    end else begin
      rd_sync[0]   <= bus.ebus_rd_n;
      wr_sync[0]   <= bus.ebus_wr_n;
      mreq_sync[0] <= bus.ebus_mreq_n;
      iorq_sync[0] <= bus.ebus_iorq_n;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        rd_sync[i] <= rd_sync[i-1];
        wr_sync[i] <= wr_sync[i-1];
      end
      for (int i = 1; i < int'(QL_W); i++) begin
        mreq_sync[i] <= mreq_sync[i-1];
        iorq_sync[i] <= iorq_sync[i-1];
      end
    end
  end

  assign rd_stb = rd_sync[SYNC_STAGES-1] & ~rd_sync[SYNC_STAGES-2];
  assign wr_stb = wr_sync[SYNC_STAGES-1] & ~wr_sync[SYNC_STAGES-2];
  assign rd_hi  = rd_sync[SYNC_STAGES-1];
  assign mreq_q = mreq_sync[QL_W-1];
  assign iorq_q = iorq_sync[QL_W-1];
  assign cyc_ok = mreq_q ^ iorq_q;

  // Write data tracks the raw bus while WR# is low, so it is settled by the
  // time the synchronised strobe fires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdata_q <= '0;
    end else if (!bus.ebus_wr_n) begin
      wdata_q <= bus.ebus_d_in;
    end
  end

  // A same-cycle RD#/WR# collision keeps the write and discards the read.
  assign push_wr  = wr_stb & cyc_ok;
  assign push_rd  = rd_stb & cyc_ok & ~wr_stb;
  assign push     = push_wr | push_rd;
  assign both_stb = rd_stb & wr_stb & cyc_ok;

  always_comb begin
    new_txn.addr  = bus.ebus_a;
    new_txn.data  = push_wr ? wdata_q : '0;
    new_txn.is_wr = push_wr;
    new_txn.is_io = ~iorq_q;
  end

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign pop     = (count != '0) & bus.txn_ready;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  // Transaction FIFO; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= new_txn;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head           = mem[rd_ptr];
  assign bus.txn_valid  = (count != '0);
  assign bus.txn_addr   = head.addr;
  assign bus.txn_wrdata = head.data;
  assign bus.txn_is_wr  = head.is_wr;
  assign bus.txn_is_io  = head.is_io;

  // Read response state register and bus driver.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      d_oe_q  <= 1'b0;
      d_out_q <= '0;
    end else begin
      state  <= state_nxt;
      d_oe_q <= (state_nxt == ST_DRIVE);
      if (d_ld) begin
        d_out_q <= bus.rsp_data;
      end
    end
  end

  // Read response next state: one read outstanding; a response with no
  // read waiting is reported as late, a second read strobe restarts.
  always_comb begin
    state_nxt = state;
    d_ld      = 1'b0;
    late_set  = 1'b0;
    fsm_perr  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.rsp_valid) begin
          late_set = 1'b1;
        end
        if (push_rd) begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (push_rd) begin
          state_nxt = ST_WAIT;
          fsm_perr  = 1'b1;
        end else if (bus.rsp_valid && !rd_hi) begin
          state_nxt = ST_DRIVE;
          d_ld      = 1'b1;
        end else if (rd_hi) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (push_rd) begin
          state_nxt = ST_WAIT;
          fsm_perr  = 1'b1;
        end else if (rd_hi) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.ebus_d_oe  = d_oe_q;
  assign bus.ebus_d_out = d_out_q;

  // Sticky flags: a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      late_rsp_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      overflow_q  <= drop | (overflow_q & ~bus.err_clr);
      late_rsp_q  <= late_set | (late_rsp_q & ~bus.err_clr);
      proto_err_q <= both_stb | fsm_perr | (proto_err_q & ~bus.err_clr);
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.late_rsp  = late_rsp_q;
  assign bus.proto_err = proto_err_q;

endmodule
